// File: rtl/trng_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : trng_pkg                                               |
// | Description : Shared TRNG datapath constants and types used by      |
// |               markov16, markov_vn_extractor and fifo16.             |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package trng_pkg;
  // Markov lane index width; one lane per preceding 4-bit state
  localparam int LANE_W    = 4;
  localparam int NUM_LANES = 1 << LANE_W;
  // Group width handed to fifo16 on its valid/bits input
  localparam int GROUP_W   = 6;
  // Health counter width
  localparam int CNT_W     = 16;

  typedef logic [LANE_W-1:0] lane_t;
endpackage

`default_nettype wire

// File: rtl/bit_packer.sv
// +----------------------------------------------------------------------+
// | Module      : bit_packer                                             |
// | Description : Packs extracted bits into GROUP_W-slot groups, slot 0  |
// |               oldest; emits full groups or flushes partial ones.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module bit_packer
  import trng_pkg::*;
#(
  parameter int GROUP_W = trng_pkg::GROUP_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_valid,
  input  logic               in_bit,
  input  logic               flush,
  output logic [GROUP_W-1:0] out_valid,
  output logic [GROUP_W-1:0] out_bits
);

  localparam int c_FILL_W = $clog2(GROUP_W + 1);

  logic [c_FILL_W-1:0] r_cnt;
  logic [c_FILL_W-1:0] w_fill;
  logic [GROUP_W-1:0]  r_stg;
  logic [GROUP_W-1:0]  w_stg;
  logic [GROUP_W-1:0]  w_mask;
  logic                w_emit;

  // Fold this cycle's extracted bit into the staging word, then decide
  // whether a full group or a flushed partial group leaves this edge.
  always_comb begin
    w_stg  = r_stg;
    w_fill = r_cnt;
    w_mask = '0;
    if (bit_valid) begin
      w_stg[r_cnt] = in_bit;
      w_fill       = r_cnt + c_FILL_W'(1);
    end
    for (int i = 0; i < GROUP_W; i++) begin
      w_mask[i] = (c_FILL_W'(i) < w_fill);
    end
    // A completed group takes priority; flush then has nothing left to do
    w_emit = (w_fill == c_FILL_W'(GROUP_W)) || (flush && (w_fill != '0));
  end

  // Staging/count register and registered single-cycle group output
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_stg     <= '0;
      out_valid <= '0;
      out_bits  <= '0;
    end else if (w_emit) begin
      r_cnt     <= '0;
      r_stg     <= '0;
      out_valid <= w_mask;
      out_bits  <= w_stg & w_mask;
    end else begin
      r_cnt     <= w_fill;
      r_stg     <= w_stg;
      out_valid <= '0;
      out_bits  <= '0;
    end
  end

endmodule

`default_nettype wire

// File: rtl/markov_vn_extractor.sv
// +----------------------------------------------------------------------+
// | Module      : markov_vn_extractor                                    |
// | Description : Per-Markov-lane von Neumann (Blum) debiaser with group |
// |               packing and saturating raw/extracted bit counters.     |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module markov_vn_extractor
  import trng_pkg::*;
#(
  parameter int LANE_W  = trng_pkg::LANE_W,
  parameter int GROUP_W = trng_pkg::GROUP_W,
  parameter int CNT_W   = trng_pkg::CNT_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic               in_bit,
  input  logic [LANE_W-1:0]  in_lane,
  input  logic               flush,
  input  logic               stat_clear,
  output logic [GROUP_W-1:0] out_valid,
  output logic [GROUP_W-1:0] out_bits,
  output logic [CNT_W-1:0]   stat_in_cnt,
  output logic [CNT_W-1:0]   stat_out_cnt
);

  localparam int              c_NUM_LANES = 1 << LANE_W;
  localparam logic [CNT_W-1:0] c_CNT_MAX  = {CNT_W{1'b1}};

  logic [c_NUM_LANES-1:0] r_pend;
  logic [c_NUM_LANES-1:0] r_held;
  logic                   w_sel_pend;
  logic                   w_sel_held;
  logic                   w_ext_valid;
  logic                   w_ext_bit;

  // Look up the addressed lane; a second, differing bit yields the held bit
  always_comb begin
    w_sel_pend  = r_pend[in_lane];
    w_sel_held  = r_held[in_lane];
    w_ext_valid = in_valid && w_sel_pend && (w_sel_held != in_bit);
    w_ext_bit   = w_sel_held;
  end

  // Lane pairing state: single-cycle read-modify-write, so back-to-back
  // bits on one lane always see the updated pending flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_held <= '0;
    end else if (in_valid) begin
      r_pend[in_lane] <= ~w_sel_pend;
      if (!w_sel_pend) begin
        r_held[in_lane] <= in_bit;
      end
    end
  end

  // Saturating health counters; clear overrides a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset || stat_clear) begin
      stat_in_cnt  <= '0;
      stat_out_cnt <= '0;
    end else begin
      if (in_valid && (stat_in_cnt != c_CNT_MAX)) begin
        stat_in_cnt <= stat_in_cnt + CNT_W'(1);
      end
      if (w_ext_valid && (stat_out_cnt != c_CNT_MAX)) begin
        stat_out_cnt <= stat_out_cnt + CNT_W'(1);
      end
    end
  end

  bit_packer #(
    .GROUP_W (GROUP_W)
  ) u_bit_packer (
    .clk       (clk),
    .reset     (reset),
    .bit_valid (w_ext_valid),
    .in_bit    (w_ext_bit),
    .flush     (flush),
    .out_valid (out_valid),
    .out_bits  (out_bits)
  );

endmodule

`default_nettype wire

// File: tb/tb_markov_vn_extractor.sv
// +----------------------------------------------------------------------+
// | Module      : tb_markov_vn_extractor                                 |
// | Description : Directed + model-checked bench for markov_vn_extractor |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_markov_vn_extractor;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic [3:0]  in_lane = '0;
  logic        flush = 1'b0;
  logic        stat_clear = 1'b0;
  logic [5:0]  out_valid;
  logic [5:0]  out_bits;
  logic [15:0] stat_in_cnt;
  logic [15:0] stat_out_cnt;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state: per-lane pending bit (-1 = none) and the
  // queue of extracted bits not yet handed out
  int         m_pend [16];
  bit         m_q[$];
  logic [5:0] exp_valid = '0;
  logic [5:0] exp_bits = '0;
  int         exp_in = 0;
  int         exp_out = 0;
  bit         checking = 1'b0;

  always #5 clk = ~clk;

  markov_vn_extractor dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_bit       (in_bit),
    .in_lane      (in_lane),
    .flush        (flush),
    .stat_clear   (stat_clear),
    .out_valid    (out_valid),
    .out_bits     (out_bits),
    .stat_in_cnt  (stat_in_cnt),
    .stat_out_cnt (stat_out_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs sampled at that edge
  task automatic model_edge(input bit v, input bit b, input int lane, input bit fl,
                            input bit clr, input bit rs);
    if (rs) begin
      foreach (m_pend[i]) m_pend[i] = -1;
      m_q.delete();
      exp_valid = '0;
      exp_bits  = '0;
      exp_in    = 0;
      exp_out   = 0;
      return;
    end
    exp_valid = '0;
    exp_bits  = '0;
    if (v) begin
      if (exp_in < 65535) exp_in++;
      if (m_pend[lane] < 0) begin
        m_pend[lane] = b;
      end else begin
        if (m_pend[lane] != int'(b)) begin
          m_q.push_back(m_pend[lane] == 1);
          if (exp_out < 65535) exp_out++;
        end
        m_pend[lane] = -1;
      end
    end
    if (m_q.size() == 6 || (fl && m_q.size() > 0)) begin
      for (int i = 0; i < m_q.size(); i++) begin
        exp_valid[i] = 1'b1;
        exp_bits[i]  = m_q[i];
      end
      m_q.delete();
    end
    if (clr) begin
      exp_in  = 0;
      exp_out = 0;
    end
  endtask

  // Drive one cycle; returns at the following falling edge
  task automatic step(input bit v, input bit b, input int lane, input bit fl = 0,
                      input bit clr = 0, input bit rs = 0);
    in_valid   = v;
    in_bit     = b;
    in_lane    = lane[3:0];
    flush      = fl;
    stat_clear = clr;
    reset      = rs;
    @(posedge clk);
    model_edge(v, b, lane, fl, clr, rs);
    checking = 1'b1;
    @(negedge clk);
    in_valid   = 1'b0;
    in_bit     = 1'b0;
    flush      = 1'b0;
    stat_clear = 1'b0;
    reset      = 1'b0;
  endtask

  task automatic pair(input int lane, input bit first, input bit second);
    step(1, first, lane);
    step(1, second, lane);
  endtask

  // Cycle-by-cycle comparison against the model
  always @(negedge clk) begin
    if (checking) begin
      check("model_out_valid", 32'(out_valid), 32'(exp_valid));
      check("model_out_bits", 32'(out_bits), 32'(exp_bits));
      check("model_stat_in", 32'(stat_in_cnt), 32'(exp_in));
      check("model_stat_out", 32'(stat_out_cnt), 32'(exp_out));
    end
  end

  initial begin
    // Reset state
    step(0, 0, 0, 0, 0, 1);
    check("reset_out_valid", 32'(out_valid), 32'h0);
    check("reset_stat_in", 32'(stat_in_cnt), 32'h0);

    // Lane 3 pair 10, then five more 10 pairs on lanes 0..4 -> full group of ones
    pair(3, 1, 0);
    for (int l = 0; l < 5; l++) pair(l, 1, 0);
    check("t1_out_valid", 32'(out_valid), 32'h3F);
    check("t1_out_bits", 32'(out_bits), 32'h3F);
    check("t1_stat_in", 32'(stat_in_cnt), 32'd12);
    check("t1_stat_out", 32'(stat_out_cnt), 32'd6);

    // Equal pairs are discarded
    step(0, 0, 0, 0, 0, 1);
    pair(7, 1, 1);
    pair(7, 0, 0);
    check("t2_out_valid", 32'(out_valid), 32'h0);
    check("t2_stat_in", 32'(stat_in_cnt), 32'd4);
    check("t2_stat_out", 32'(stat_out_cnt), 32'd0);

    // Interleaved lanes pair independently; flush emits the partial group
    step(0, 0, 0, 0, 0, 1);
    step(1, 0, 2);
    step(1, 1, 5);
    step(1, 1, 2);
    step(1, 0, 5);
    step(0, 0, 0, 1);
    check("t3_out_valid", 32'(out_valid), 32'h03);
    check("t3_out_bits", 32'(out_bits), 32'h02);

    // Extraction order 1,0,1,1,0,0 lands slot 0 first; pulse lasts one cycle
    step(0, 0, 0, 0, 0, 1);
    pair(0, 1, 0); pair(0, 0, 1); pair(0, 1, 0);
    pair(0, 1, 0); pair(0, 0, 1); pair(0, 0, 1);
    check("t4_out_valid", 32'(out_valid), 32'h3F);
    check("t4_out_bits", 32'(out_bits), 32'h0D);
    step(0, 0, 0);
    check("t4_pulse_end", 32'(out_valid), 32'h0);

    // Reset drops a partial group and a pending half-pair
    step(0, 0, 0, 0, 0, 1);
    pair(1, 1, 0); pair(1, 0, 1); pair(1, 1, 0);
    step(1, 1, 9);
    step(0, 0, 0, 0, 0, 1);
    check("t5_reset_no_pulse", 32'(out_valid), 32'h0);
    step(1, 0, 9);
    step(0, 0, 0, 1);
    check("t5_lane9_first_bit", 32'(out_valid), 32'h0);
    check("t5_stat_out", 32'(stat_out_cnt), 32'd0);

    // Mixed random traffic with flushes and clears, checked against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, $urandom % 4,
           ($urandom % 10) == 0, ($urandom % 50) == 0);
    end

    // Raw counter saturation, then clear wins over a coincident increment
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 65540; i++) step(1, $urandom % 2, $urandom % 16);
    check("t6_sat_in", 32'(stat_in_cnt), 32'hFFFF);
    step(1, 1, 0, 0, 1);
    check("t6_clear_in", 32'(stat_in_cnt), 32'h0);
    check("t6_clear_out", 32'(stat_out_cnt), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
